// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - issue/writeback sequencer for the 32-bit combinational ALU.
// Optional retire/overflow counters are enabled by defining RETIRE_CNT_EN.
module alu_issue_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_opcode,
  output logic              alu_sub,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_o,
  output logic [3:0]        flags,
  output logic              done,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`ifdef RETIRE_CNT_EN
  ,
  output logic [15:0]       retire_cnt,
  output logic [15:0]       ovf_cnt
`endif
);

  localparam int NREG = 2 ** REG_AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_t;

  state_t state, state_next;

  logic [2:0]        op_q;
  logic              sub_q;
  logic              cin_q;
  logic              use_imm_q;
  logic [REG_AW-1:0] rd_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [IMM_W-1:0]  imm_q;

  logic [DATA_W-1:0] hold_result;
  logic [3:0]        hold_flags;

  logic [DATA_W-1:0] rf [NREG];
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic [DATA_W-1:0] imm_ext;
  logic              accept;

  // Bit 16 of the instruction word carries no meaning.
  logic unused_bits;
  assign unused_bits = instr[16];

  assign accept   = instr_valid & instr_ready;
  assign rs1_val  = (rs1_q == '0) ? '0 : rf[rs1_q];
  assign rs2_val  = (rs2_q == '0) ? '0 : rf[rs2_q];
  assign imm_ext  = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
  assign dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = rst_n;
        if (accept) state_next = S_READ;
      end
      S_READ:  state_next = S_EXEC;
      S_EXEC:  state_next = S_WB;
      S_WB:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      sub_q     <= 1'b0;
      cin_q     <= 1'b0;
      use_imm_q <= 1'b0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
    end else if (accept) begin
      op_q      <= instr[31:29];
      sub_q     <= instr[28];
      cin_q     <= instr[27];
      use_imm_q <= instr[26];
      rd_q      <= instr[23 +: REG_AW];
      rs1_q     <= instr[20 +: REG_AW];
      rs2_q     <= instr[17 +: REG_AW];
      imm_q     <= instr[IMM_W-1:0];
    end
  end

  // ALU inputs are registered so the ALU gets a full cycle to settle in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      alu_sub    <= 1'b0;
      alu_cin    <= 1'b0;
    end else if (state == S_READ) begin
      alu_a      <= rs1_val;
      alu_b      <= use_imm_q ? imm_ext : rs2_val;
      alu_opcode <= op_q;
      alu_sub    <= sub_q;
      alu_cin    <= cin_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_result <= '0;
      hold_flags  <= '0;
    end else if (state == S_EXEC) begin
      hold_result <= alu_result;
      hold_flags  <= {alu_cout, alu_o, alu_n, alu_z};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      flags <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state == S_WB);
      if (state == S_WB) begin
        flags <= hold_flags;
        if (rd_q != '0) rf[rd_q] <= hold_result;
      end
    end
  end

`ifdef RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
      ovf_cnt    <= '0;
    end else if (state == S_WB) begin
      retire_cnt <= retire_cnt + 16'd1;
      if (hold_flags[2]) ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
`endif

endmodule
